// File: rtl/score_display_driver.sv
// Drives a 4-digit multiplexed 7-segment display from the current and high score.
// Scores are converted to BCD with a sequential double-dabble engine; game-over triggers a blink.
module score_display_driver #(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned BLINK_PERIOD  = 2500000,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [6:0] currScore,
  input  logic [6:0] highScore,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int unsigned TogW   = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_PERIOD - 1);
  localparam logic [TogW-1:0]   TogMax   = TogW'(BLINK_TOGGLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} conv_state_e;

  conv_state_e      state_q;
  logic [6:0]       bin_q;
  logic [11:0]      bcd_q;
  logic [2:0]       n_q;
  logic             sel_high_q;
  logic [6:0]       cap_q;
  logic [6:0]       shown_curr_q;
  logic [6:0]       shown_high_q;
  // digits_q[0]=curr ones, [1]=curr tens, [2]=high ones, [3]=high tens
  logic [3:0][3:0]  digits_q;

  logic [ScanW-1:0] scan_cnt_q;
  logic [1:0]       scan_idx_q;

  logic              gc_prev_q;
  logic              blink_active_q;
  logic              blank_q;
  logic [BlinkW-1:0] blink_timer_q;
  logic [TogW-1:0]   blink_tog_q;

  logic [11:0] bcd_adj;
  logic [18:0] dd_shift;
  logic [3:0]  commit_tens;
  logic [3:0]  commit_ones;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign dd_shift = {bcd_adj, bin_q} << 1;

  // Two display digits only: anything with a hundreds digit saturates to 99.
  always_comb begin
    commit_tens = bcd_q[7:4];
    commit_ones = bcd_q[3:0];
    if (bcd_q[11:8] != 4'd0) begin
      commit_tens = 4'd9;
      commit_ones = 4'd9;
    end
  end

  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= StIdle;
      bin_q        <= '0;
      bcd_q        <= '0;
      n_q          <= '0;
      sel_high_q   <= 1'b0;
      cap_q        <= '0;
      shown_curr_q <= '0;
      shown_high_q <= '0;
      digits_q     <= '0;
      busy         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (currScore != shown_curr_q) begin
            cap_q      <= currScore;
            bin_q      <= currScore;
            sel_high_q <= 1'b0;
            bcd_q      <= '0;
            n_q        <= '0;
            busy       <= 1'b1;
            state_q    <= StShift;
          end else if (highScore != shown_high_q) begin
            cap_q      <= highScore;
            bin_q      <= highScore;
            sel_high_q <= 1'b1;
            bcd_q      <= '0;
            n_q        <= '0;
            busy       <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          bcd_q <= dd_shift[18:7];
          bin_q <= dd_shift[6:0];
          n_q   <= n_q + 3'd1;
          if (n_q == 3'd6) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          if (sel_high_q) begin
            digits_q[3]  <= commit_tens;
            digits_q[2]  <= commit_ones;
            shown_high_q <= cap_q;
          end else begin
            digits_q[1]  <= commit_tens;
            digits_q[0]  <= commit_ones;
            shown_curr_q <= cap_q;
          end
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
    end else begin
      if (scan_cnt_q == ScanMax) begin
        scan_cnt_q <= '0;
        scan_idx_q <= scan_idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      if (blank_q) begin
        an  <= 4'hF;
        seg <= 7'h7F;
      end else begin
        an  <= ~(4'b0001 << scan_idx_q);
        seg <= font(digits_q[scan_idx_q]);
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      gc_prev_q      <= 1'b0;
      blink_active_q <= 1'b0;
      blank_q        <= 1'b0;
      blink_timer_q  <= '0;
      blink_tog_q    <= '0;
    end else begin
      gc_prev_q <= isGameComplete;
      if (isGameComplete && !gc_prev_q) begin
        blink_active_q <= 1'b1;
        blank_q        <= 1'b1;
        blink_timer_q  <= '0;
        blink_tog_q    <= '0;
      end else if (blink_active_q) begin
        if (blink_timer_q == BlinkMax) begin
          blink_timer_q <= '0;
          if (blink_tog_q == TogMax) begin
            blink_active_q <= 1'b0;
            blank_q        <= 1'b0;
            blink_tog_q    <= '0;
          end else begin
            blank_q     <= ~blank_q;
            blink_tog_q <= blink_tog_q + 1'b1;
          end
        end else begin
          blink_timer_q <= blink_timer_q + 1'b1;
        end
      end
    end
  end

endmodule
